// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux_sched_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter must be able to represent MAX_HOLD itself.
  function automatic int unsigned hold_w(input int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Request/grant bundle between the requesters and the mux scheduler.
interface mux16_rr_sched_if;
  import mux_sched_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] gnt;
  logic               valid;

  modport master (output en, output req, input sel, input gnt, input valid);
  modport slave  (input en, input req, output sel, output gnt, output valid);

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first active request after ptr, ending at ptr itself.
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W:0]       start;
  logic [SEL_W-1:0]     off;

  // Rotate so ptr+1 lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    start = {1'b0, ptr} + (SEL_W+1)'(1);
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> start);
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = SEL_W'(start) + off;
    any = |req;
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing a 16:1 mux among 16 requesters, with bounded grant bursts.
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  mux16_rr_sched_if.slave  bus
);

  localparam int unsigned HOLD_W = hold_w(MAX_HOLD);

  state_t             state_q, state_nxt;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic [SEL_W-1:0]   last_q, last_nxt;
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic               valid_q, valid_nxt;
  logic               rel;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  // While granting, the search resumes after the current owner.
  assign pick_ptr = (state_q == GRANT) ? sel_q : last_q;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      last_q  <= last_nxt;
      hold_q  <= hold_nxt;
      gnt_q   <= gnt_nxt;
      valid_q <= valid_nxt;
    end
  end

  // Next-state: a release re-arbitrates at the same edge, so there is no idle bubble.
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    last_nxt  = last_q;
    hold_nxt  = hold_q;
    rel       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_any) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        rel = !bus.en || !bus.req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD));
        if (!rel) begin
          hold_nxt = hold_q + HOLD_W'(1);
        end else begin
          last_nxt = sel_q;
          if (bus.en && pick_any) begin
            sel_nxt  = pick_idx;
            hold_nxt = HOLD_W'(1);
          end else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so gnt/valid are registered alongside sel.
  always_comb begin
    gnt_nxt   = '0;
    valid_nxt = (state_nxt == GRANT);
    if (valid_nxt) gnt_nxt[sel_nxt] = 1'b1;
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed plus constrained-random bench for mux16_rr_sched at MAX_HOLD of 8, 2 and 1.
module tb_mux16_rr_sched;
  import mux_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mux16_rr_sched_if b8();
  mux16_rr_sched_if b2();
  mux16_rr_sched_if b1();

  mux16_rr_sched #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  mux16_rr_sched #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  mux16_rr_sched #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [15:0] r);
    b8.en = e; b8.req = r;
    b2.en = e; b2.req = r;
    b1.en = e; b1.req = r;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int          rot2 [10] = '{0, 0, 5, 5, 10, 10, 15, 15, 0, 0};
  int          rot1 [10] = '{0, 5, 10, 15, 0, 5, 10, 15, 0, 5};
  int          waitc [16];
  int          max_wait;
  logic [15:0] prev_req;
  logic [15:0] nreq;

  initial begin
    // Reset with every requester active.
    rst_n = 1'b0;
    drive(1'b1, 16'hFFFF);
    tick(); tick();
    chk("rst_sel",   32'(b8.sel),   32'd0);
    chk("rst_gnt",   32'(b8.gnt),   32'h0);
    chk("rst_valid", 32'(b8.valid), 32'd0);
    chk("rst_last",  32'(u_dut8.last_q), 32'd15);

    rst_n = 1'b1;
    tick();
    chk("first_gnt8",  32'(b8.gnt),   32'h0001);
    chk("first_sel8",  32'(b8.sel),   32'd0);
    chk("first_val8",  32'(b8.valid), 32'd1);
    chk("first_gnt1",  32'(b1.gnt),   32'h0001);

    // Lone requester 4 held for 20 cycles: grant never drops, hold restarts every 8.
    drive(1'b1, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("burst_gnt",  32'(b8.gnt),   32'h0010);
      chk("burst_val",  32'(b8.valid), 32'd1);
      chk("burst_hold", 32'(u_dut8.hold_q), 32'((i % 8) + 1));
    end

    // Rotation over 0,5,10,15 at MAX_HOLD=2 and MAX_HOLD=1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h8421);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rot2_sel", 32'(b2.sel), 32'(rot2[i]));
      chk("rot2_gnt", 32'(b2.gnt), 32'(32'd1 << rot2[i]));
      chk("rot1_sel", 32'(b1.sel), 32'(rot1[i]));
    end

    // Early release: owner 3 drops after 2 cycles, 7 takes over with no gap.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h0088);
    tick();
    chk("early_gnt_a", 32'(b8.gnt), 32'h0008);
    tick();
    chk("early_hold",  32'(u_dut8.hold_q), 32'd2);
    drive(1'b1, 16'h0080);
    tick();
    chk("early_gnt_b", 32'(b8.gnt),   32'h0080);
    chk("early_val",   32'(b8.valid), 32'd1);

    // Enable low during a grant forces idle and keeps sel.
    drive(1'b0, 16'h0080);
    tick();
    chk("en_off_val", 32'(b8.valid), 32'd0);
    chk("en_off_gnt", 32'(b8.gnt),   32'h0);
    chk("en_off_sel", 32'(b8.sel),   32'd7);
    tick();
    chk("en_off_idle", 32'(b8.valid), 32'd0);
    drive(1'b1, 16'h0080);
    tick();
    chk("en_on_gnt", 32'(b8.gnt), 32'h0080);

    // Reset mid-burst.
    rst_n = 1'b0;
    tick();
    chk("mid_rst_gnt",  32'(b8.gnt),   32'h0);
    chk("mid_rst_val",  32'(b8.valid), 32'd0);
    chk("mid_rst_sel",  32'(b8.sel),   32'd0);
    chk("mid_rst_last", 32'(u_dut8.last_q), 32'd15);
    chk("mid_rst_hold", 32'(u_dut8.hold_q), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", 32'(b8.sel), 32'd7);

    // Wrap-around: owner 15 hands over to the lowest active index.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h8000);
    tick();
    chk("wrap_own", 32'(b8.gnt), 32'h8000);
    drive(1'b1, 16'h0006);
    tick();
    chk("wrap_next", 32'(b8.gnt), 32'h0002);
    chk("wrap_sel",  32'(b8.sel), 32'd1);

    // Random traffic: invariants every cycle and a starvation bound for MAX_HOLD=8.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prev_req = 16'h0;
    max_wait = 0;
    for (int i = 0; i < 16; i++) waitc[i] = 0;
    drive(1'b1, prev_req);
    for (int c = 0; c < 400; c++) begin
      tick();
      chk("rnd_onehot8", 32'($onehot0(b8.gnt)), 32'd1);
      chk("rnd_onehot2", 32'($onehot0(b2.gnt)), 32'd1);
      chk("rnd_onehot1", 32'($onehot0(b1.gnt)), 32'd1);
      chk("rnd_gsel8",   32'(b8.gnt[b8.sel]), 32'(b8.valid));
      chk("rnd_gsel2",   32'(b2.gnt[b2.sel]), 32'(b2.valid));
      chk("rnd_gsel1",   32'(b1.gnt[b1.sel]), 32'(b1.valid));
      nreq = prev_req;
      for (int i = 0; i < 16; i++) begin
        if (prev_req[i] && !b8.gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
        if (b8.gnt[i]) begin
          if ($urandom_range(3) == 0) nreq[i] = 1'b0;
        end else if (!prev_req[i]) begin
          if ($urandom_range(7) == 0) nreq[i] = 1'b1;
        end
      end
      prev_req = nreq;
      drive(1'b1, prev_req);
    end
    chk("starve_bound", 32'(max_wait <= 121), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
